// File: rtl/decimal_align_sequencer.sv
// decimal_align_sequencer: multi-cycle BCD significand aligner for the decimal subtractor.
// Ports: clk/rst_n (async active-low); in_valid/in_ready with M1,M2 (BCD) and E1,E2 (biased exps);
//        out_valid/out_ready with M1_norm,M2_norm, GRS_bits {guard,round,sticky}, E_res (max exp),
//        Greater (E1>=E2, M2 shifted).
// Option: define DEC_ALIGN_DUAL_SHIFT_EN to shift up to two digits per cycle (identical results).
module decimal_align_sequencer #(
    parameter int DIGITS = 7,
    parameter int EXP_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   M1,
    input  logic [4*DIGITS-1:0]   M2,
    input  logic [EXP_W-1:0]      E1,
    input  logic [EXP_W-1:0]      E2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   M1_norm,
    output logic [4*DIGITS-1:0]   M2_norm,
    output logic [8:0]            GRS_bits,
    output logic [EXP_W-1:0]      E_res,
    output logic                  Greater
);
    localparam int MW = 4 * DIGITS;
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
    // Beyond DIGITS+2 digits every further shift is a no-op on the result.
    localparam logic [EXP_W:0] CLAMP = (EXP_W+1)'(DIGITS + 2);

    logic [1:0]       state_q, state_d;
    logic [MW-1:0]    m1_q, m1_d, m2_q, m2_d, sel, shifted;
    logic [3:0]       g_q, g_d, r_q, r_d, cnt_q, cnt_d;
    logic             s_q, s_d, gt_q, gt_d, two;
    logic [EXP_W-1:0] e_q, e_d;
    logic [EXP_W:0]   diff;

    always_comb begin
        state_d = state_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        g_d     = g_q;
        r_d     = r_q;
        s_d     = s_q;
        e_d     = e_q;
        gt_d    = gt_q;
        cnt_d   = cnt_q;
        sel     = gt_q ? m2_q : m1_q;
`ifdef DEC_ALIGN_DUAL_SHIFT_EN
        two     = cnt_q > 4'd1;
`else
        two     = 1'b0;
`endif
        shifted = two ? sel >> 8 : sel >> 4;
        diff    = (E1 >= E2) ? {1'b0, E1} - {1'b0, E2} : {1'b0, E2} - {1'b0, E1};
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = SHIFT;
                m1_d    = M1;
                m2_d    = M2;
                gt_d    = E1 >= E2;
                e_d     = (E1 >= E2) ? E1 : E2;
                cnt_d   = (diff > CLAMP) ? CLAMP[3:0] : diff[3:0];
                g_d     = '0;
                r_d     = '0;
                s_d     = 1'b0;
            end
            SHIFT: if (cnt_q == '0) begin
                state_d = DONE;
            end else begin
                if (gt_q) m2_d = shifted;
                else      m1_d = shifted;
                // A two-digit step pushes both the old guard and old round past round.
                g_d   = two ? sel[7:4] : sel[3:0];
                r_d   = two ? sel[3:0] : g_q;
                s_d   = s_q | (r_q != '0) | (two && g_q != '0);
                cnt_d = cnt_q - (two ? 4'd2 : 4'd1);
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m1_q    <= '0;
            m2_q    <= '0;
            g_q     <= '0;
            r_q     <= '0;
            s_q     <= 1'b0;
            e_q     <= '0;
            gt_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            g_q     <= g_d;
            r_q     <= r_d;
            s_q     <= s_d;
            e_q     <= e_d;
            gt_q    <= gt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign M1_norm   = m1_q;
    assign M2_norm   = m2_q;
    assign GRS_bits  = {g_q, r_q, s_q};
    assign E_res     = e_q;
    assign Greater   = gt_q;
endmodule

// File: tb/tb_decimal_align_sequencer.sv
// tb_decimal_align_sequencer: scoreboard bench with a digit-level reference model.
module tb_decimal_align_sequencer;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [27:0] M1 = 0, M2 = 0;
    logic [7:0]  E1 = 0, E2 = 0;
    logic        in_ready, out_valid, Greater;
    logic [27:0] M1_norm, M2_norm;
    logic [8:0]  GRS_bits;
    logic [7:0]  E_res;

    decimal_align_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .M1(M1), .M2(M2), .E1(E1), .E2(E2), .out_valid(out_valid), .out_ready(out_ready),
        .M1_norm(M1_norm), .M2_norm(M2_norm), .GRS_bits(GRS_bits), .E_res(E_res), .Greater(Greater)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] m1, m2;
        logic [8:0]  grs;
        logic [7:0]  e;
        logic        gt;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
    logic prev_v = 0, auto_rdy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] dg(input logic [27:0] m, input int i);
        if (i < 0 || i > 6) return 4'h0;
        return m[4*i +: 4];
    endfunction

    // Reference: shift by k digits in one go, read guard/round/sticky off the original digits.
    function automatic exp_t model(input logic [27:0] a, input logic [7:0] ea,
                                   input logic [27:0] b, input logic [7:0] eb);
        exp_t x;
        int r, k;
        logic [27:0] sh;
        logic s;
        x.gt = ea >= eb;
        x.e  = x.gt ? ea : eb;
        r    = x.gt ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
        k    = r > 9 ? 9 : r;
        sh   = x.gt ? b : a;
        s    = 0;
        for (int i = 0; i < k - 2; i++) s |= dg(sh, i) != 0;
        x.grs = {(k >= 1 ? dg(sh, k - 1) : 4'h0), (k >= 2 ? dg(sh, k - 2) : 4'h0), s};
        x.m1  = x.gt ? a : 28'(a >> (4 * k));
        x.m2  = x.gt ? 28'(b >> (4 * k)) : b;
`ifdef DEC_ALIGN_DUAL_SHIFT_EN
        x.lat = (k + 1) / 2 + 1;
`else
        x.lat = k + 1;
`endif
        return x;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) if (auto_rdy) begin
        #1 out_ready = $urandom_range(0, 3) != 0;
    end

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cyc = cyc;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out", out_valid, 0);
            end else begin
                cur = q[0];
                if (!prev_v) check("latency", 64'(cyc - acc_cyc - 1), 64'(cur.lat));
                check("M1_norm", M1_norm, cur.m1);
                check("M2_norm", M2_norm, cur.m2);
                check("GRS_bits", GRS_bits, cur.grs);
                check("E_res", E_res, cur.e);
                check("Greater", Greater, cur.gt);
                if (out_ready) void'(q.pop_front());
            end
        end
        prev_v = out_valid;
    end

    task automatic send(input logic [27:0] a, input logic [7:0] ea, input logic [27:0] b, input logic [7:0] eb);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", in_ready, 1);
            return;
        end
        M1 = a; E1 = ea; M2 = b; E2 = eb; in_valid = 1;
        q.push_back(model(a, ea, b, eb));
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 64'(q.size()), 0);
    endtask

    function automatic logic [27:0] rnd_m();
        logic [27:0] m;
        for (int i = 0; i < 7; i++)
            m[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
        return m;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_outs"}, {M1_norm, M2_norm, GRS_bits, E_res, Greater}, 0);
    endtask

    initial begin
        int e1, e2, n;
        repeat (2) @(posedge clk);
        #1 check_idle_zero("reset");
        rst_n = 1;
        @(posedge clk); #1;
        send(28'h1234567, 8'h65, 28'h7654321, 8'h63); drain();
        send(28'h0000015, 8'h10, 28'h9999999, 8'h20); drain();
        send(28'h2468024, 8'h40, 28'h1357913, 8'h40); drain();
        send(28'h2345678, 8'h48, 28'h1000001, 8'h40); drain();
        // Backpressure: hold DONE while new operands are offered.
        out_ready = 0;
        send(28'h1234567, 8'h65, 28'h7654321, 8'h63);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_reach_done", out_valid, 1);
        repeat (5) begin
            in_valid = 1; M1 = rnd_m(); M2 = rnd_m(); E1 = 8'($urandom); E2 = 8'($urandom);
            @(posedge clk); #1;
            check("bp_in_ready_low", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_after", out_valid, 0);
        check("bp_queue_empty", 64'(q.size()), 0);
        // Randomised back-to-back traffic with random out_ready.
        auto_rdy = 1;
        repeat (40) begin
            e1 = $urandom_range(0, 255);
            e2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : e1 + int'($urandom_range(0, 24)) - 12;
            e2 = e2 < 0 ? 0 : (e2 > 255 ? 255 : e2);
            send(rnd_m(), 8'(e1), rnd_m(), 8'(e2));
        end
        drain();
        auto_rdy = 0;
        @(posedge clk); #2;
        out_ready = 1;
        @(posedge clk); #1;
        // Reset in the middle of a k=9 shift.
        send(28'h1111111, 8'h10, 28'h9876543, 8'h50);
        repeat (3) @(posedge clk);
        #1 check("mr_busy", in_ready, 0);
        rst_n = 0;
        #1 check_idle_zero("mid_reset");
        q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        send(28'h0505050, 8'h33, 28'h7000007, 8'h33); drain();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
